match_sequencer: RTL and testbench

- Top-level game controller for the FPGA cricket game.
- Turns the raw delivery and team-switch buttons into debounced bowl requests, handshakes each request with the outcome datapath (LFSR-driven run/wicket generator), and accumulates balls, wickets and runs per innings.
- Ends each innings, computes the target, and declares the winner.
- The score display and LED logic read its outputs.

---
 rtl/match_sequencer_if.sv | 49 ++++
 rtl/match_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_match_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/match_sequencer_if.sv
// Bundle between the match sequencer, the outcome datapath and the score/LED readers.
// The sequencer drives the request and score fields; the outcome datapath drives the outcome fields.
interface match_sequencer_if;
    logic       bowl_req;
    logic       outcome_valid;
    logic [2:0] outcome_runs;
    logic       outcome_wicket;
    logic       batting_team;
    logic [6:0] balls;
    logic [3:0] wickets;
    logic [7:0] runs;
    logic [8:0] target;
    logic       inning_over;
    logic       game_over;
    logic [1:0] winner;
    logic       busy;

    modport master (
        output bowl_req,
        output batting_team,
        output balls,
        output wickets,
        output runs,
        output target,
        output inning_over,
        output game_over,
        output winner,
        output busy,
        input  outcome_valid,
        input  outcome_runs,
        input  outcome_wicket
    );

    modport slave (
        input  bowl_req,
        input  batting_team,
        input  balls,
        input  wickets,
        input  runs,
        input  target,
        input  inning_over,
        input  game_over,
        input  winner,
        input  busy,
        output outcome_valid,
        output outcome_runs,
        output outcome_wicket
    );
endinterface

// File: rtl/match_sequencer.sv
// Cricket match controller: debounces the two buttons, handshakes each delivery with the
// outcome datapath, keeps the per-innings score and decides the result.
module match_sequencer #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int MAX_BALLS       = 120,
    parameter int MAX_WICKETS     = 10,
    parameter int OUTCOME_TIMEOUT = 15
) (
    input  logic               clk_fpga,
    input  logic               reset,
    input  logic               delivery_btn,
    input  logic               switch_btn,
    match_sequencer_if.master  bus
);

    localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TOW = $clog2(OUTCOME_TIMEOUT + 1);
    localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TOW-1:0] TMO_LAST = TOW'(OUTCOME_TIMEOUT - 1);
    localparam logic [6:0]     BALL_LIM = 7'(MAX_BALLS);
    localparam logic [3:0]     WKT_LIM  = 4'(MAX_WICKETS);

    typedef enum logic [1:0] {
        READY        = 2'd0,
        WAIT_OUTCOME = 2'd1,
        INN_BREAK    = 2'd2,
        DONE         = 2'd3
    } state_t;

    // Bit 0 is the delivery button, bit 1 the team-switch button.
    logic [1:0]     sync1_q, sync1_d;
    logic [1:0]     sync2_q, sync2_d;
    logic [1:0]     stable_q, stable_d;
    logic [1:0]     press_q, press_d;
    logic [DBW-1:0] db_cnt_q [2];
    logic [DBW-1:0] db_cnt_d [2];

    state_t         state_q, state_d;
    logic [TOW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic           bowl_req_q, bowl_req_d;
    logic           batting_team_q, batting_team_d;
    logic [6:0]     balls_q, balls_d;
    logic [3:0]     wickets_q, wickets_d;
    logic [7:0]     runs_q, runs_d;
    logic [8:0]     target_q, target_d;
    logic           inning_over_q, inning_over_d;
    logic           game_over_q, game_over_d;
    logic [1:0]     winner_q, winner_d;
    logic           busy_q, busy_d;

    logic           del_p;
    logic           sw_p;
    logic           tmo_hit_s;
    logic           ball_done_s;
    logic [2:0]     runs_add_s;
    logic [8:0]     runs_sum_s;
    logic [6:0]     balls_n_s;
    logic [3:0]     wickets_n_s;
    logic [7:0]     runs_n_s;
    logic           end_hit_s;

    assign del_p = press_q[0];
    assign sw_p  = press_q[1];

    // Synchronizers and debouncers: a level change is accepted once it has been seen
    // on DEBOUNCE_CYCLES consecutive samples; only accepted rising levels produce a pulse.
    always_comb begin
        sync1_d = {switch_btn, delivery_btn};
        sync2_d = sync1_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = {DBW{1'b0}};
            stable_d[i] = stable_q[i];
            press_d[i]  = 1'b0;
            if (sync2_q[i] == stable_q[i]) begin
                db_cnt_d[i] = {DBW{1'b0}};
            end else if (db_cnt_q[i] == DB_LAST) begin
                stable_d[i] = sync2_q[i];
                press_d[i]  = sync2_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + {{(DBW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Candidate score after the ball that is being closed in this cycle.
    always_comb begin
        tmo_hit_s   = (tmo_cnt_q == TMO_LAST);
        ball_done_s = bus.outcome_valid || tmo_hit_s;
        runs_add_s  = (bus.outcome_runs == 3'd7) ? 3'd6 : bus.outcome_runs;
        runs_sum_s  = {1'b0, runs_q} + {6'd0, runs_add_s};
        balls_n_s   = balls_q + 7'd1;
        wickets_n_s = wickets_q;
        runs_n_s    = runs_q;
        if (bus.outcome_valid && bus.outcome_wicket) begin
            wickets_n_s = wickets_q + 4'd1;
        end else if (bus.outcome_valid) begin
            runs_n_s = runs_sum_s[8] ? 8'hFF : runs_sum_s[7:0];
        end else begin
            runs_n_s = runs_q;
        end
        end_hit_s = (wickets_n_s == WKT_LIM) || (balls_n_s == BALL_LIM);
    end

    // Next-state and next-output logic of the match FSM.
    always_comb begin
        state_d        = state_q;
        tmo_cnt_d      = tmo_cnt_q;
        bowl_req_d     = 1'b0;
        batting_team_d = batting_team_q;
        balls_d        = balls_q;
        wickets_d      = wickets_q;
        runs_d         = runs_q;
        target_d       = target_q;
        inning_over_d  = inning_over_q;
        game_over_d    = game_over_q;
        winner_d       = winner_q;
        case (state_q)
            READY: begin
                if (del_p) begin
                    bowl_req_d = 1'b1;
                    tmo_cnt_d  = {TOW{1'b0}};
                    state_d    = WAIT_OUTCOME;
                end else begin
                    state_d = READY;
                end
            end
            WAIT_OUTCOME: begin
                if (ball_done_s) begin
                    balls_d   = balls_n_s;
                    wickets_d = wickets_n_s;
                    runs_d    = runs_n_s;
                    state_d   = READY;
                    if (!batting_team_q) begin
                        if (end_hit_s) begin
                            state_d       = INN_BREAK;
                            inning_over_d = 1'b1;
                            target_d      = {1'b0, runs_n_s} + 9'd1;
                        end else begin
                            state_d = READY;
                        end
                    end else if ({1'b0, runs_n_s} >= target_q) begin
                        state_d       = DONE;
                        winner_d      = 2'b10;
                        inning_over_d = 1'b1;
                        game_over_d   = 1'b1;
                    end else if (end_hit_s) begin
                        state_d       = DONE;
                        winner_d      = ({1'b0, runs_n_s} == (target_q - 9'd1)) ? 2'b11 : 2'b01;
                        inning_over_d = 1'b1;
                        game_over_d   = 1'b1;
                    end else begin
                        state_d = READY;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + {{(TOW-1){1'b0}}, 1'b1};
                end
            end
            INN_BREAK: begin
                if (sw_p) begin
                    batting_team_d = 1'b1;
                    balls_d        = 7'd0;
                    wickets_d      = 4'd0;
                    runs_d         = 8'd0;
                    inning_over_d  = 1'b0;
                    state_d        = READY;
                end else begin
                    state_d = INN_BREAK;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = READY;
            end
        endcase
        busy_d = (state_d == WAIT_OUTCOME);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_fpga) begin
        if (!reset) begin
            sync1_q        <= 2'b00;
            sync2_q        <= 2'b00;
            stable_q       <= 2'b00;
            press_q        <= 2'b00;
            db_cnt_q[0]    <= {DBW{1'b0}};
            db_cnt_q[1]    <= {DBW{1'b0}};
            state_q        <= READY;
            tmo_cnt_q      <= {TOW{1'b0}};
            bowl_req_q     <= 1'b0;
            batting_team_q <= 1'b0;
            balls_q        <= 7'd0;
            wickets_q      <= 4'd0;
            runs_q         <= 8'd0;
            target_q       <= 9'd0;
            inning_over_q  <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 2'b00;
            busy_q         <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            press_q        <= press_d;
            db_cnt_q[0]    <= db_cnt_d[0];
            db_cnt_q[1]    <= db_cnt_d[1];
            state_q        <= state_d;
            tmo_cnt_q      <= tmo_cnt_d;
            bowl_req_q     <= bowl_req_d;
            batting_team_q <= batting_team_d;
            balls_q        <= balls_d;
            wickets_q      <= wickets_d;
            runs_q         <= runs_d;
            target_q       <= target_d;
            inning_over_q  <= inning_over_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.bowl_req     = bowl_req_q;
    assign bus.batting_team = batting_team_q;
    assign bus.balls        = balls_q;
    assign bus.wickets      = wickets_q;
    assign bus.runs         = runs_q;
    assign bus.target       = target_q;
    assign bus.inning_over  = inning_over_q;
    assign bus.game_over    = game_over_q;
    assign bus.winner       = winner_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_match_sequencer.sv
// Directed bench for match_sequencer: debounce, scoring, innings switch, tie, chase,
// timeout/simultaneity and reset during a pending delivery.
module tb_match_sequencer;

    logic clk_fpga = 1'b0;
    logic reset;
    logic delivery_btn;
    logic switch_btn;
    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    int   bowl_cnt = 0;
    int   c0;
    bit   seen;

    match_sequencer_if bus();

    match_sequencer #(
        .DEBOUNCE_CYCLES(4),
        .MAX_BALLS      (6),
        .MAX_WICKETS    (2),
        .OUTCOME_TIMEOUT(8)
    ) dut (
        .clk_fpga    (clk_fpga),
        .reset       (reset),
        .delivery_btn(delivery_btn),
        .switch_btn  (switch_btn),
        .bus         (bus)
    );

    always #5 clk_fpga = ~clk_fpga;

    // Each bowl_req pulse spans exactly one posedge-to-posedge interval, so it is counted once.
    always @(posedge clk_fpga) begin
        if (bus.bowl_req === 1'b1) bowl_cnt <= bowl_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_fpga);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_score(input string tag, input int b, input int w, input int r);
        check({tag, ".balls"},   32'(bus.balls),   32'(b));
        check({tag, ".wickets"}, 32'(bus.wickets), 32'(w));
        check({tag, ".runs"},    32'(bus.runs),    32'(r));
    endtask

    task automatic check_all_zero(input string tag);
        check_score(tag, 0, 0, 0);
        check({tag, ".bowl_req"},     32'(bus.bowl_req),     32'd0);
        check({tag, ".batting_team"}, 32'(bus.batting_team), 32'd0);
        check({tag, ".target"},       32'(bus.target),       32'd0);
        check({tag, ".inning_over"},  32'(bus.inning_over),  32'd0);
        check({tag, ".game_over"},    32'(bus.game_over),    32'd0);
        check({tag, ".winner"},       32'(bus.winner),       32'd0);
        check({tag, ".busy"},         32'(bus.busy),         32'd0);
    endtask

    task automatic do_reset();
        reset              = 1'b0;
        delivery_btn       = 1'b0;
        switch_btn         = 1'b0;
        bus.outcome_valid  = 1'b0;
        bus.outcome_runs   = 3'd0;
        bus.outcome_wicket = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic wait_bowl(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.bowl_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic deliver(input int r, input bit w);
        bit f;
        delivery_btn = 1'b1;
        wait_bowl(f);
        check("bowl_seen", 32'(f), 32'd1);
        delivery_btn       = 1'b0;
        bus.outcome_valid  = 1'b1;
        bus.outcome_runs   = 3'(r);
        bus.outcome_wicket = w;
        tick(1);
        bus.outcome_valid  = 1'b0;
        bus.outcome_runs   = 3'd0;
        bus.outcome_wicket = 1'b0;
        tick(8);
    endtask

    task automatic press_switch();
        switch_btn = 1'b1;
        tick(10);
        switch_btn = 1'b0;
        tick(8);
    endtask

    task automatic innings1();
        deliver(4, 1'b0);
        deliver(6, 1'b0);
        deliver(5, 1'b1);
        check_score("inn1_mid", 3, 1, 10);
        check("inn1_mid.inning_over", 32'(bus.inning_over), 32'd0);
        deliver(1, 1'b0);
        deliver(7, 1'b0);
        deliver(0, 1'b0);
    endtask

    initial begin
        do_reset();
        check_all_zero("reset");

        // Bounce filter: three short bursts, then a steady press.
        c0 = bowl_cnt;
        repeat (3) begin
            delivery_btn = 1'b1;
            tick(3);
            delivery_btn = 1'b0;
            tick(1);
        end
        check("bounce.no_bowl", 32'(bowl_cnt - c0), 32'd0);
        delivery_btn = 1'b1;
        tick(10);
        delivery_btn = 1'b0;
        tick(14);
        check("bounce.one_bowl", 32'(bowl_cnt - c0), 32'd1);
        check_score("bounce.dot", 1, 0, 0);
        check("bounce.busy", 32'(bus.busy), 32'd0);

        // Scoring through a full first innings.
        do_reset();
        innings1();
        check_score("inn1_end", 6, 1, 17);
        check("inn1_end.inning_over", 32'(bus.inning_over), 32'd1);
        check("inn1_end.target", 32'(bus.target), 32'd18);
        check("inn1_end.game_over", 32'(bus.game_over), 32'd0);
        c0 = bowl_cnt;
        delivery_btn = 1'b1;
        tick(10);
        delivery_btn = 1'b0;
        tick(8);
        check("brk.del_ignored", 32'(bowl_cnt - c0), 32'd0);
        check_score("brk.hold", 6, 1, 17);

        // Innings switch, then all out one run short: tie.
        press_switch();
        check("sw.batting_team", 32'(bus.batting_team), 32'd1);
        check_score("sw.cleared", 0, 0, 0);
        check("sw.inning_over", 32'(bus.inning_over), 32'd0);
        check("sw.target_held", 32'(bus.target), 32'd18);
        deliver(6, 1'b0);
        deliver(6, 1'b0);
        deliver(5, 1'b0);
        deliver(0, 1'b1);
        check("tie.not_over", 32'(bus.game_over), 32'd0);
        deliver(3, 1'b1);
        check_score("tie.end", 5, 2, 17);
        check("tie.game_over", 32'(bus.game_over), 32'd1);
        check("tie.inning_over", 32'(bus.inning_over), 32'd1);
        check("tie.winner", 32'(bus.winner), 32'd3);
        c0 = bowl_cnt;
        delivery_btn = 1'b1;
        switch_btn   = 1'b1;
        tick(10);
        delivery_btn = 1'b0;
        switch_btn   = 1'b0;
        tick(8);
        check("done.no_bowl", 32'(bowl_cnt - c0), 32'd0);
        check("done.winner_held", 32'(bus.winner), 32'd3);
        check("done.batting_held", 32'(bus.batting_team), 32'd1);

        // Successful chase.
        do_reset();
        innings1();
        press_switch();
        deliver(6, 1'b0);
        deliver(6, 1'b0);
        check("chase.not_over", 32'(bus.game_over), 32'd0);
        deliver(6, 1'b0);
        check_score("chase.end", 3, 0, 18);
        check("chase.game_over", 32'(bus.game_over), 32'd1);
        check("chase.winner", 32'(bus.winner), 32'd2);

        // Timeout: a withheld outcome closes the ball as a dot after exactly 8 cycles.
        do_reset();
        delivery_btn = 1'b1;
        wait_bowl(seen);
        check("tmo.bowl_seen", 32'(seen), 32'd1);
        delivery_btn = 1'b0;
        tick(7);
        check("tmo.still_busy", 32'(bus.busy), 32'd1);
        check("tmo.balls_before", 32'(bus.balls), 32'd0);
        tick(1);
        check("tmo.busy_clear", 32'(bus.busy), 32'd0);
        check_score("tmo.dot", 1, 0, 0);
        tick(8);

        // Second press landing inside WAIT_OUTCOME, outcome in the timeout cycle.
        c0 = bowl_cnt;
        delivery_btn = 1'b1;
        tick(4);
        delivery_btn = 1'b0;
        tick(3);
        check("sim.bowl_latency", 32'(bus.bowl_req), 32'd1);
        tick(1);
        delivery_btn = 1'b1;
        tick(6);
        bus.outcome_valid = 1'b1;
        bus.outcome_runs  = 3'd3;
        tick(1);
        bus.outcome_valid = 1'b0;
        bus.outcome_runs  = 3'd0;
        check_score("sim.valid_wins", 2, 0, 3);
        check("sim.busy", 32'(bus.busy), 32'd0);
        tick(10);
        check("sim.one_bowl", 32'(bowl_cnt - c0), 32'd1);
        delivery_btn = 1'b0;
        tick(8);

        // Reset while an outcome is pending; the late outcome is ignored.
        delivery_btn = 1'b1;
        wait_bowl(seen);
        check("rst.bowl_seen", 32'(seen), 32'd1);
        delivery_btn = 1'b0;
        reset        = 1'b0;
        tick(1);
        reset = 1'b1;
        bus.outcome_valid = 1'b1;
        bus.outcome_runs  = 3'd4;
        tick(1);
        bus.outcome_valid = 1'b0;
        bus.outcome_runs  = 3'd0;
        tick(1);
        check_all_zero("rst_mid");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
